intersection_ctrl: RTL and testbench

INTERSECTION_CTRL -- requirements
Module: intersection_ctrl

---
 rtl/intersection_ctrl_if.sv | 23 ++
 rtl/intersection_ctrl.sv | 109 ++++++++++
 tb/tb_intersection_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/intersection_ctrl_if.sv
// Signal bundle between the intersection controller and its sensors and lamps.
// The controller is the slave side. The environment drives the sensors and watches the lamps.
interface intersection_ctrl_if;
  logic       tick;
  logic       ew_req;
  logic       ped_req;
  logic       emg;
  logic [1:0] ns_color;
  logic [1:0] ew_color;
  logic       walk;
  logic       ped_pending;
  logic [2:0] phase;

  modport master (
    output tick, ew_req, ped_req, emg,
    input  ns_color, ew_color, walk, ped_pending, phase
  );

  modport slave (
    input  tick, ew_req, ped_req, emg,
    output ns_color, ew_color, walk, ped_pending, phase
  );
endinterface

// File: rtl/intersection_ctrl.sv
// Two-road traffic light controller with a pedestrian walk phase and emergency preemption.
// NS rests on green. EW gets a fixed green slot when there is demand.
module intersection_ctrl #(
  parameter int MIN_GREEN = 8,
  parameter int EW_GREEN  = 6,
  parameter int YELLOW    = 3,
  parameter int ALL_RED   = 2
) (
  input  logic               clk,
  input  logic               rst,
  intersection_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_NS_GREEN  = 3'd0,
    S_NS_YELLOW = 3'd1,
    S_ALL_RED_A = 3'd2,
    S_EW_GREEN  = 3'd3,
    S_EW_YELLOW = 3'd4,
    S_ALL_RED_B = 3'd5,
    S_EMG_HOLD  = 3'd6
  } state_t;

  localparam logic [1:0] C_RED    = 2'd0;
  localparam logic [1:0] C_GREEN  = 2'd1;
  localparam logic [1:0] C_YELLOW = 2'd2;

  localparam logic [7:0] L_MIN_GREEN = 8'(MIN_GREEN - 1);
  localparam logic [7:0] L_EW_GREEN  = 8'(EW_GREEN - 1);
  localparam logic [7:0] L_YELLOW    = 8'(YELLOW - 1);
  localparam logic [7:0] L_ALL_RED   = 8'(ALL_RED - 1);

  state_t     r_state;
  logic [7:0] r_timer;
  logic       r_walk;
  logic       r_pend;
  logic [1:0] r_ns;
  logic [1:0] r_ew;
  state_t     w_next;
  logic       w_sat;
  logic       w_ew_entry;

  // Timed states leave on the tick that completes their last period.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_NS_GREEN:
        if (bus.emg || (bus.tick && r_timer == L_MIN_GREEN && (bus.ew_req || r_pend)))
          w_next = S_NS_YELLOW;
      S_NS_YELLOW:
        if (bus.tick && r_timer == L_YELLOW) w_next = S_ALL_RED_A;
      S_ALL_RED_A:
        if (bus.tick && r_timer == L_ALL_RED) w_next = bus.emg ? S_EMG_HOLD : S_EW_GREEN;
      S_EW_GREEN:
        if (bus.emg || (bus.tick && r_timer == L_EW_GREEN)) w_next = S_EW_YELLOW;
      S_EW_YELLOW:
        if (bus.tick && r_timer == L_YELLOW) w_next = S_ALL_RED_B;
      S_ALL_RED_B:
        if (bus.tick && r_timer == L_ALL_RED) w_next = bus.emg ? S_EMG_HOLD : S_NS_GREEN;
      S_EMG_HOLD:
        if (!bus.emg) w_next = S_NS_GREEN;
      default:
        w_next = S_ALL_RED_B;
    endcase
  end

  assign w_sat      = (r_state == S_NS_GREEN) && (r_timer == L_MIN_GREEN);
  assign w_ew_entry = (w_next == S_EW_GREEN) && (r_state != S_EW_GREEN);

  // Lamp outputs are decoded from the next state, so they change on the same edge as the phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_ALL_RED_B;
      r_timer <= 8'd0;
      r_walk  <= 1'b0;
      r_pend  <= 1'b0;
      r_ns    <= C_RED;
      r_ew    <= C_RED;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_timer <= 8'd0;
      else if (bus.tick && !w_sat && r_state != S_EMG_HOLD)
        r_timer <= r_timer + 8'd1;

      r_ns <= (w_next == S_NS_GREEN)  ? C_GREEN :
              (w_next == S_NS_YELLOW) ? C_YELLOW : C_RED;
      r_ew <= (w_next == S_EW_GREEN)  ? C_GREEN :
              (w_next == S_EW_YELLOW) ? C_YELLOW : C_RED;

      // A press on the EW-green entry edge is served by that same walk phase.
      if (w_ew_entry) begin
        r_walk <= r_pend | bus.ped_req;
        r_pend <= 1'b0;
      end else begin
        r_walk <= r_walk && (w_next == S_EW_GREEN);
        if (bus.ped_req && !(r_state == S_EW_GREEN && r_walk))
          r_pend <= 1'b1;
      end
    end
  end

  assign bus.phase       = r_state;
  assign bus.ns_color    = r_ns;
  assign bus.ew_color    = r_ew;
  assign bus.walk        = r_walk;
  assign bus.ped_pending = r_pend;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Directed bench for intersection_ctrl at default parameters.
// Inputs are driven and outputs are sampled on the falling clock edge.
module tb_intersection_ctrl;

  logic clk;
  logic rst;
  int   testsRun;
  int   testsFailed;
  int   cycleCount;
  bit   tickDiv;

  intersection_ctrl_if bus();

  intersection_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute bound on the run, in case the controller stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    cycleCount++;
    bus.tick = tickDiv ? (cycleCount % 4 == 0) : 1'b1;
  endtask

  task automatic checkOne(input string tag, input int got, input int exp);
    testsRun++;
    assert (got === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input int ph, input int walkE, input int pendE);
    int nsE;
    int ewE;
    nsE = (ph == 0) ? 1 : (ph == 1) ? 2 : 0;
    ewE = (ph == 3) ? 1 : (ph == 4) ? 2 : 0;
    checkOne({tag, ".phase"}, int'(bus.phase), ph);
    checkOne({tag, ".ns_color"}, int'(bus.ns_color), nsE);
    checkOne({tag, ".ew_color"}, int'(bus.ew_color), ewE);
    checkOne({tag, ".walk"}, int'(bus.walk), walkE);
    checkOne({tag, ".ped_pending"}, int'(bus.ped_pending), pendE);
    checkOne({tag, ".oneRoadOnly"}, int'(bus.ns_color != 2'd0 && bus.ew_color != 2'd0), 0);
  endtask

  task automatic runPhase(input string tag, input int ph, input int n, input int walkE, input int pendE);
    checkOutput(tag, ph, walkE, pendE);
    for (int i = 1; i < n; i++) begin
      cyc();
      checkOutput(tag, ph, walkE, pendE);
    end
  endtask

  task automatic fullCycle(input int pendBefore, input int walkE);
    runPhase("nsYellow", 1, 3, 0, pendBefore);
    cyc();
    runPhase("allRedA", 2, 2, 0, pendBefore);
    cyc();
    runPhase("ewGreen", 3, 6, walkE, 0);
    cyc();
    runPhase("ewYellow", 4, 3, 0, 0);
    cyc();
    runPhase("allRedB", 5, 2, 0, 0);
    cyc();
    checkOutput("nsGreenBack", 0, 0, 0);
  endtask

  task automatic applyStimulus();
    int n;
    int guard;

    // Reset and the clearance period that follows it.
    rst = 1'b1;
    bus.tick = 1'b1;
    bus.ew_req = 1'b0;
    bus.ped_req = 1'b0;
    bus.emg = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset", 5, 0, 0);
    rst = 1'b0;
    cyc();
    checkOutput("clearance", 5, 0, 0);
    cyc();
    runPhase("idleGreen", 0, 50, 0, 0);

    // Sustained EW demand gives the full rotation and then minimum NS green.
    bus.ew_req = 1'b1;
    cyc();
    fullCycle(0, 0);
    runPhase("nsGreenMin", 0, 8, 0, 0);
    cyc();
    bus.ew_req = 1'b0;
    fullCycle(0, 0);

    // A single pedestrian pulse with no EW traffic.
    runPhase("nsHold", 0, 12, 0, 0);
    bus.ped_req = 1'b1;
    cyc();
    bus.ped_req = 1'b0;
    checkOutput("pedLatched", 0, 0, 1);
    cyc();
    fullCycle(1, 1);

    // A press on the EW-entry edge is served. A press during the walk is ignored.
    bus.ew_req = 1'b1;
    runPhase("nsGreenMin2", 0, 8, 0, 0);
    cyc();
    bus.ew_req = 1'b0;
    runPhase("nsYellow2", 1, 3, 0, 0);
    cyc();
    runPhase("allRedA2", 2, 2, 0, 0);
    bus.ped_req = 1'b1;
    cyc();
    bus.ped_req = 1'b0;
    checkOutput("pedAtEntry", 3, 1, 0);
    bus.ped_req = 1'b1;
    cyc();
    bus.ped_req = 1'b0;
    checkOutput("pedIgnored", 3, 1, 0);
    cyc();
    runPhase("ewGreen2", 3, 4, 1, 0);
    cyc();
    runPhase("ewYellow2", 4, 3, 0, 0);
    cyc();
    runPhase("allRedB2", 5, 2, 0, 0);
    cyc();
    checkOutput("nsGreen2", 0, 0, 0);

    // Emergency preemption at NS green clock 3. The press latched with it survives.
    cyc();
    cyc();
    bus.emg = 1'b1;
    bus.ped_req = 1'b1;
    cyc();
    bus.ped_req = 1'b0;
    runPhase("emgYellow", 1, 3, 0, 1);
    cyc();
    runPhase("emgAllRed", 2, 2, 0, 1);
    cyc();
    runPhase("emgHold", 6, 5, 0, 1);
    bus.emg = 1'b0;
    cyc();
    checkOutput("emgRelease", 0, 0, 1);

    // Tick only on every fourth clock stretches the timed states.
    tickDiv = 1'b1;
    guard = 0;
    while (bus.phase != 3'd1 && guard < 200) begin
      cyc();
      guard++;
    end
    checkOne("slowTickReachYellow", int'(guard < 200), 1);
    n = 0;
    while (bus.phase == 3'd1 && n < 100) begin
      n++;
      cyc();
    end
    checkOne("slowTickYellowLen", n, 12);
    n = 0;
    while (bus.phase == 3'd2 && n < 100) begin
      n++;
      cyc();
    end
    checkOne("slowTickAllRedLen", n, 8);
    checkOutput("slowTickEwGreen", 3, 1, 0);

    // Asynchronous reset in the middle of a walk phase.
    tickDiv = 1'b0;
    cyc();
    checkOutput("ewGreenMid", 3, 1, 0);
    rst = 1'b1;
    #1;
    checkOutput("asyncReset", 5, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc();
    checkOutput("rstClear", 5, 0, 0);
    cyc();
    checkOutput("rstGreen", 0, 0, 0);
  endtask

  initial begin
    testsRun = 0;
    testsFailed = 0;
    cycleCount = 0;
    tickDiv = 1'b0;
    applyStimulus();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
